shift_unit_iter: RTL

Iterative 32-bit shift unit fed by the shift-amount/operand select path of the multicycle datapath. It loads an operand and a shift amount on a `start` strobe, shifts one bit position per clock, and raises a one-cycle `done` with the result. The control unit holds the instruction step until `done` is seen.

---
 rtl/shift_unit_iter.sv | 105 ++++++++++
 1 files changed

// File: rtl/shift_unit_iter.sv
// Iterative shift unit: loads an operand on start, shifts one bit per clock,
// and pulses done for one cycle with the result.
module shift_unit_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbgState
);

  // Handshake: start is sampled only in IDLE (starts while busy are dropped);
  // done is a one-cycle pulse with result valid in that same cycle.
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [SHW-1:0] COUNT_ONE = SHW'(1);
  localparam logic [SHW-1:0] COUNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] resultNext;
  logic [SHW-1:0]   count, countNext;
  logic [2:0]       opReg, opNext;
  logic             unusedShamtBits;

  assign unusedShamtBits = ^in_shamt[WIDTH-1:SHW];

  function automatic logic isShiftOp(input logic [2:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA) || (o == OP_ROR);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      opReg  <= 3'b000;
    end else begin
      state  <= stateNext;
      result <= resultNext;
      count  <= countNext;
      opReg  <= opNext;
    end
  end

  always_comb begin
    stateNext  = state;
    resultNext = result;
    countNext  = count;
    opNext     = opReg;
    case (state)
      IDLE: begin
        if (start) begin
          resultNext = in_data;
          countNext  = in_shamt[SHW-1:0];
          opNext     = op;
          // Zero shifts and pass-through ops skip straight to the done pulse.
          if ((in_shamt[SHW-1:0] == COUNT_ZERO) || !isShiftOp(op)) begin
            stateNext = DONE;
          end else begin
            stateNext = SHIFT;
          end
        end
      end
      SHIFT: begin
        case (opReg)
          OP_SLL:  resultNext = {result[WIDTH-2:0], 1'b0};
          OP_SRL:  resultNext = {1'b0, result[WIDTH-1:1]};
          OP_SRA:  resultNext = {result[WIDTH-1], result[WIDTH-1:1]};
          OP_ROR:  resultNext = {result[0], result[WIDTH-1:1]};
          default: resultNext = result;
        endcase
        countNext = count - COUNT_ONE;
        if (count == COUNT_ONE) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dbgState = state;

endmodule
